alu_result_buf: RTL and testbench

- Downstream stage of the ALU right-shift unit.
- Captures the shifter's WIDTH-bit result through a valid/ready handshake into a 2-entry FIFO.
- Each stored result carries status flags: zero and negative, plus parity when the optional feature is compiled in.
- Presents results to the writeback/consumer stage with its own valid/ready handshake; decouples shifter timing from consumer stalls.

---
 rtl/alu_result_buf_if.sv | 38 +++
 rtl/alu_result_buf.sv | 119 +++++++++++
 tb/tb_alu_result_buf.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_buf_if.sv
// Handshake bundle between the right-shift unit, the result buffer and the writeback consumer.
// par_flag exists only when RESULT_PARITY_EN is defined.
interface alu_result_buf_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             zero_flag;
  logic             neg_flag;
`ifdef RESULT_PARITY_EN
  logic             par_flag;

  modport master (
    output in_valid, data_in, flush, out_ready,
    input  in_ready, out_valid, data_out, zero_flag, neg_flag, par_flag
  );

  modport slave (
    input  in_valid, data_in, flush, out_ready,
    output in_ready, out_valid, data_out, zero_flag, neg_flag, par_flag
  );
`else
  modport master (
    output in_valid, data_in, flush, out_ready,
    input  in_ready, out_valid, data_out, zero_flag, neg_flag
  );

  modport slave (
    input  in_valid, data_in, flush, out_ready,
    output in_ready, out_valid, data_out, zero_flag, neg_flag
  );
`endif
endinterface

// File: rtl/alu_result_buf.sv
// Two-entry result FIFO behind the ALU right-shift unit, with per-entry zero/neg flags.
// Optional parity flag per entry when RESULT_PARITY_EN is defined.
module alu_result_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_buf_if.slave  bus,
  output logic [CNT_W-1:0] result_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             neg;
`ifdef RESULT_PARITY_EN
    logic             par;
`endif
  } entry_t;

  // Flags are fixed at push time so the output side never recomputes them.
  function automatic entry_t make_entry(input logic signed [WIDTH-1:0] d);
    entry_t e;
    e.data = d;
    e.zero = (d == '0);
    e.neg  = (d < 0);
`ifdef RESULT_PARITY_EN
    e.par  = ^d;
`endif
    return e;
  endfunction

  entry_t           mem_q [2];
  entry_t           head_q, head_d;
  entry_t           new_entry;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready;
  logic             push;
  logic             pop;

  assign new_entry = make_entry(bus.data_in);
  assign in_ready  = (count_q < 2'd2) && !bus.flush;
  assign push      = bus.in_valid && in_ready;
  assign pop       = valid_q && bus.out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    head_d   = head_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      // Head register tracks the entry at the read pointer; it holds when the FIFO drains.
      if (push && (count_q == 2'd0 || pop)) begin
        head_d = new_entry;
      end else if (pop && count_q == 2'd2) begin
        head_d = mem_q[~rd_ptr_q];
      end
      valid_d = (count_d != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      cnt_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage contents are don't-care after reset; only pointers and occupancy matter.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.data_out  = head_q.data;
  assign bus.zero_flag = head_q.zero;
  assign bus.neg_flag  = head_q.neg;
`ifdef RESULT_PARITY_EN
  assign bus.par_flag  = head_q.par;
`endif
  assign result_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed, table-driven bench for alu_result_buf (CNT_W=4 so the counter wrap is reachable).
module tb_alu_result_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] result_count;
  int               n_pass;
  int               n_total;

  alu_result_buf_if #(.WIDTH(WIDTH)) bus ();

  alu_result_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .result_count (result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_do;
    logic        e_z;
    logic        e_n;
    logic [3:0]  e_rc;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic iv, input logic [31:0] din, input logic fl,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_do, input logic e_z, input logic e_n,
                              input logic [3:0] e_rc);
    vec_t v;
    v.iv = iv; v.din = din; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_do = e_do; v.e_z = e_z; v.e_n = e_n; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic iv, input logic [31:0] din, input logic fl, input logic ordy);
    bus.in_valid  = iv;
    bus.data_in   = din;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Expected values describe the state seen before the edge that consumes each vector.
    tbl[0]  = mk(0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 0, 4'd0);
    tbl[1]  = mk(1, 32'h8000_0000, 0, 1, 1, 0, 32'h0,         0, 0, 4'd0);
    tbl[2]  = mk(0, 32'h0,         0, 1, 1, 1, 32'h8000_0000, 0, 1, 4'd0);
    tbl[3]  = mk(0, 32'h0,         0, 0, 1, 0, 32'h8000_0000, 0, 1, 4'd1);
    tbl[4]  = mk(1, 32'h0,         0, 0, 1, 0, 32'h8000_0000, 0, 1, 4'd1);
    tbl[5]  = mk(1, 32'hFFFF_FFF0, 0, 0, 1, 1, 32'h0,         1, 0, 4'd1);
    tbl[6]  = mk(1, 32'h0000_1234, 0, 0, 0, 1, 32'h0,         1, 0, 4'd1);
    tbl[7]  = mk(0, 32'h0,         0, 1, 0, 1, 32'h0,         1, 0, 4'd1);
    tbl[8]  = mk(0, 32'h0,         0, 1, 1, 1, 32'hFFFF_FFF0, 0, 1, 4'd2);
    tbl[9]  = mk(0, 32'h0,         0, 0, 1, 0, 32'hFFFF_FFF0, 0, 1, 4'd3);
    tbl[10] = mk(1, 32'h5,         0, 0, 1, 0, 32'hFFFF_FFF0, 0, 1, 4'd3);
    tbl[11] = mk(1, 32'h7,         0, 1, 1, 1, 32'h5,         0, 0, 4'd3);
    tbl[12] = mk(0, 32'h0,         0, 0, 1, 1, 32'h7,         0, 0, 4'd4);
    tbl[13] = mk(1, 32'h9,         0, 0, 1, 1, 32'h7,         0, 0, 4'd4);
    tbl[14] = mk(1, 32'hAAAA_AAAA, 1, 1, 0, 1, 32'h7,         0, 0, 4'd4);
    tbl[15] = mk(0, 32'h0,         0, 1, 1, 0, 32'h7,         0, 0, 4'd4);
    tbl[16] = mk(1, 32'h3,         0, 0, 1, 0, 32'h7,         0, 0, 4'd4);
    tbl[17] = mk(0, 32'h0,         0, 1, 1, 1, 32'h3,         0, 0, 4'd4);
    tbl[18] = mk(0, 32'h0,         0, 0, 1, 0, 32'h3,         0, 0, 4'd5);

    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].iv, tbl[i].din, tbl[i].fl, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d.in_ready", i),  {31'b0, bus.in_ready},  {31'b0, tbl[i].e_ir});
      chk($sformatf("v%0d.out_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].e_ov});
      chk($sformatf("v%0d.data_out", i),  bus.data_out,           tbl[i].e_do);
      chk($sformatf("v%0d.zero", i),      {31'b0, bus.zero_flag}, {31'b0, tbl[i].e_z});
      chk($sformatf("v%0d.neg", i),       {31'b0, bus.neg_flag},  {31'b0, tbl[i].e_n});
      chk($sformatf("v%0d.count", i),     {28'b0, result_count},  {28'b0, tbl[i].e_rc});
      tick();
    end

    // Reset wins over a simultaneous push and pop-ready.
    drive(1'b1, 32'h0000_000F, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.data_out",  bus.data_out,           32'd0);
    chk("rst.count",     {28'b0, result_count},  32'd0);
    chk("rst.in_ready",  {31'b0, bus.in_ready},  32'd1);
    tick();
    chk("rst.still_empty", {31'b0, bus.out_valid}, 32'd0);

    // Streaming push+pop every cycle: 16 pops wrap the 4-bit counter back to 0.
    drive(1'b1, 32'd100, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 32'd100 + k, 1'b0, 1'b1);
      #1;
      chk($sformatf("s%0d.out_valid", k), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("s%0d.data_out", k),  bus.data_out,           32'd100 + k - 1);
      chk($sformatf("s%0d.count", k),     {28'b0, result_count},  (k - 1) % 16);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("wrap.count",    {28'b0, result_count},  32'd0);
    chk("wrap.data_out", bus.data_out,           32'd116);
    chk("wrap.valid",    {31'b0, bus.out_valid}, 32'd1);

`ifdef RESULT_PARITY_EN
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0007, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b1);
    #1;
    chk("par7.data", bus.data_out,           32'h7);
    chk("par7.par",  {31'b0, bus.par_flag},  32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("par3.data", bus.data_out,           32'h3);
    chk("par3.par",  {31'b0, bus.par_flag},  32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
